// File: rtl/ebpc_stream_mux_if.sv
// ebpc_stream_mux_if
// Groups every handshake and data signal around the EBPC stream merger
// into one bundle: the two input streams from the EBPC encoder (ZNZ and
// BPC) and the merged output stream.
//
// Signals
//   znz_data / znz_last / znz_vld / znz_rdy   ZNZ input stream
//   bpc_data / bpc_last / bpc_vld / bpc_rdy   BPC input stream
//   data / src / last / vld / rdy             merged output stream
//                                             (src: 0 = ZNZ, 1 = BPC)
//
// Modports
//   slave  : the view of the merger itself (consumes inputs, produces output)
//   master : the view of the environment (encoder side plus output sink)
interface ebpc_stream_mux_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] znz_data;
    logic              znz_last;
    logic              znz_vld;
    logic              znz_rdy;

    logic [DATA_W-1:0] bpc_data;
    logic              bpc_last;
    logic              bpc_vld;
    logic              bpc_rdy;

    logic [DATA_W-1:0] data;
    logic              src;
    logic              last;
    logic              vld;
    logic              rdy;

    modport slave (
        input  znz_data, znz_last, znz_vld,
        output znz_rdy,
        input  bpc_data, bpc_last, bpc_vld,
        output bpc_rdy,
        output data, src, last, vld,
        input  rdy
    );

    modport master (
        output znz_data, znz_last, znz_vld,
        input  znz_rdy,
        output bpc_data, bpc_last, bpc_vld,
        input  bpc_rdy,
        input  data, src, last, vld,
        output rdy
    );
endinterface

// File: rtl/ebpc_stream_mux.sv
// ebpc_stream_mux
// Merges the ZNZ and BPC streams of one EBPC-encoded frame into a single
// tagged output stream. Words are granted round-robin while both streams
// are active (ZNZ first at frame start); once one stream has delivered its
// last word only the other is accepted. The final word of the frame (the
// second stream's last) is the only one carrying last on the output.
//
// Ports
//   clk_i      clock, all state changes on the rising edge
//   rst_i      synchronous active-high reset
//   bus        ebpc_stream_mux_if.slave: ZNZ/BPC inputs and merged output
//   znz_cnt_o  ZNZ words forwarded in the current/last frame (saturating)
//   bpc_cnt_o  BPC words forwarded in the current/last frame (saturating)
//   idle_o     no frame in progress and no word held
//
// Configuration macro: EBPC_MUX_OUT_REG_EN
//   defined   : 2-entry skid register on the output, 1 cycle latency,
//               input ready does not depend combinationally on bus.rdy
//   undefined : combinational output from the granted input, 0 latency

package ebpc_pkg;
    localparam int DATA_W = 32;
endpackage

module ebpc_stream_mux #(
    parameter int DATA_W = ebpc_pkg::DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    ebpc_stream_mux_if.slave bus,
    output logic [CNT_W-1:0] znz_cnt_o,
    output logic [CNT_W-1:0] bpc_cnt_o,
    output logic             idle_o
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_RUN      = 2'd1;
    localparam logic [1:0] ST_ZNZ_DONE = 2'd2;
    localparam logic [1:0] ST_BPC_DONE = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]        state_q, state_d;
    logic              prefBpc_q, prefBpc_d;
    logic [CNT_W-1:0]  znzCnt_q, znzCnt_d;
    logic [CNT_W-1:0]  bpcCnt_q, bpcCnt_d;

    logic              allowZnz, allowBpc;
    logic              reqZnz, reqBpc;
    logic              gntZnz, gntBpc;
    logic              sideRdy;
    logic              acceptZnz, acceptBpc, anyAccept;
    logic [DATA_W-1:0] wordData;
    logic              wordSrc;
    logic              wordLast;

`ifdef EBPC_MUX_OUT_REG_EN
    logic              outVld_q, outVld_d;
    logic [DATA_W-1:0] outData_q, outData_d;
    logic              outSrc_q, outSrc_d;
    logic              outLast_q, outLast_d;
    logic              skidVld_q, skidVld_d;
    logic [DATA_W-1:0] skidData_q, skidData_d;
    logic              skidSrc_q, skidSrc_d;
    logic              skidLast_q, skidLast_d;
`else
    logic              lock_q, lock_d;
    logic              lockBpc_q, lockBpc_d;
`endif

    // Arbitration. A stream that already delivered its last word is masked
    // until the frame closes. In the combinational build a stalled output
    // freezes the grant so the presented word cannot change under the sink.
    always_comb begin
        allowZnz = (state_q != ST_ZNZ_DONE);
        allowBpc = (state_q != ST_BPC_DONE);
        reqZnz   = bus.znz_vld & allowZnz;
        reqBpc   = bus.bpc_vld & allowBpc;
`ifdef EBPC_MUX_OUT_REG_EN
        gntZnz   = reqZnz & (~reqBpc | ~prefBpc_q);
        gntBpc   = reqBpc & ~gntZnz;
        sideRdy  = ~skidVld_q;
`else
        if (lock_q) begin
            gntZnz = reqZnz & ~lockBpc_q;
            gntBpc = reqBpc & lockBpc_q;
        end else begin
            gntZnz = reqZnz & (~reqBpc | ~prefBpc_q);
            gntBpc = reqBpc & ~gntZnz;
        end
        sideRdy  = bus.rdy;
`endif
        acceptZnz = gntZnz & sideRdy & ~rst_i;
        acceptBpc = gntBpc & sideRdy & ~rst_i;
        anyAccept = acceptZnz | acceptBpc;
        wordData  = gntBpc ? bus.bpc_data : bus.znz_data;
        wordSrc   = gntBpc;
        // Only the remaining stream's last closes the frame on the output.
        wordLast  = gntBpc ? (bus.bpc_last & (state_q == ST_ZNZ_DONE))
                           : (bus.znz_last & (state_q == ST_BPC_DONE));
    end

    assign bus.znz_rdy = acceptZnz;
    assign bus.bpc_rdy = acceptBpc;

    // Frame state, round-robin pointer and per-stream counters. The first
    // accepted word of a frame clears both counters before being counted.
    always_comb begin
        state_d   = state_q;
        prefBpc_d = prefBpc_q;
        znzCnt_d  = znzCnt_q;
        bpcCnt_d  = bpcCnt_q;

        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (acceptZnz & bus.znz_last) begin
                    state_d = ST_ZNZ_DONE;
                end else if (acceptBpc & bus.bpc_last) begin
                    state_d = ST_BPC_DONE;
                end else if (anyAccept) begin
                    state_d = ST_RUN;
                end
            end
            ST_ZNZ_DONE: begin
                if (acceptBpc & bus.bpc_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                if (acceptZnz & bus.znz_last) begin
                    state_d = ST_IDLE;
                end
            end
        endcase

        if (anyAccept) begin
            prefBpc_d = acceptZnz;
        end
        if (state_d == ST_IDLE) begin
            prefBpc_d = 1'b0;
        end

        if ((state_q == ST_IDLE) && anyAccept) begin
            znzCnt_d = '0;
            bpcCnt_d = '0;
        end
        if (acceptZnz && (znzCnt_d != CNT_MAX)) begin
            znzCnt_d = znzCnt_d + CNT_ONE;
        end
        if (acceptBpc && (bpcCnt_d != CNT_MAX)) begin
            bpcCnt_d = bpcCnt_d + CNT_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            prefBpc_q <= 1'b0;
            znzCnt_q  <= '0;
            bpcCnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            prefBpc_q <= prefBpc_d;
            znzCnt_q  <= znzCnt_d;
            bpcCnt_q  <= bpcCnt_d;
        end
    end

    assign znz_cnt_o = znzCnt_q;
    assign bpc_cnt_o = bpcCnt_q;

`ifdef EBPC_MUX_OUT_REG_EN
    // Skid pair: the output slot drains to the sink; the skid slot catches
    // the word accepted in the cycle the sink stalls. Input ready is just
    // "skid slot empty", so it never depends on bus.rdy in the same cycle.
    always_comb begin
        outVld_d   = outVld_q;
        outData_d  = outData_q;
        outSrc_d   = outSrc_q;
        outLast_d  = outLast_q;
        skidVld_d  = skidVld_q;
        skidData_d = skidData_q;
        skidSrc_d  = skidSrc_q;
        skidLast_d = skidLast_q;

        if (~outVld_q | bus.rdy) begin
            if (skidVld_q) begin
                outVld_d  = 1'b1;
                outData_d = skidData_q;
                outSrc_d  = skidSrc_q;
                outLast_d = skidLast_q;
                skidVld_d = 1'b0;
            end else begin
                outVld_d = anyAccept;
                if (anyAccept) begin
                    outData_d = wordData;
                    outSrc_d  = wordSrc;
                    outLast_d = wordLast;
                end
            end
        end else if (anyAccept) begin
            skidVld_d  = 1'b1;
            skidData_d = wordData;
            skidSrc_d  = wordSrc;
            skidLast_d = wordLast;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            outVld_q   <= 1'b0;
            outData_q  <= '0;
            outSrc_q   <= 1'b0;
            outLast_q  <= 1'b0;
            skidVld_q  <= 1'b0;
            skidData_q <= '0;
            skidSrc_q  <= 1'b0;
            skidLast_q <= 1'b0;
        end else begin
            outVld_q   <= outVld_d;
            outData_q  <= outData_d;
            outSrc_q   <= outSrc_d;
            outLast_q  <= outLast_d;
            skidVld_q  <= skidVld_d;
            skidData_q <= skidData_d;
            skidSrc_q  <= skidSrc_d;
            skidLast_q <= skidLast_d;
        end
    end

    assign bus.vld  = outVld_q;
    assign bus.data = outData_q;
    assign bus.src  = outSrc_q;
    assign bus.last = outLast_q;
    assign idle_o   = (state_q == ST_IDLE) & ~outVld_q & ~skidVld_q;
`else
    // Remember a stalled grant so the next cycle presents the same word.
    always_comb begin
        lock_d    = bus.vld & ~bus.rdy;
        lockBpc_d = gntBpc;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_q    <= 1'b0;
            lockBpc_q <= 1'b0;
        end else begin
            lock_q    <= lock_d;
            lockBpc_q <= lockBpc_d;
        end
    end

    assign bus.vld  = (gntZnz | gntBpc) & ~rst_i;
    assign bus.data = bus.vld ? wordData : '0;
    assign bus.src  = bus.vld & wordSrc;
    assign bus.last = bus.vld & wordLast;
    assign idle_o   = (state_q == ST_IDLE);
`endif

endmodule

// File: tb/tb_ebpc_stream_mux.sv
// tb_ebpc_stream_mux
// Directed and randomised frames through ebpc_stream_mux. A frame-level
// model (done flags, round-robin preference, word counts, held-word queue)
// predicts every cycle's ready/valid/data/src/last/counter/idle values;
// literal expectations pin the merged order of hand-worked frames.
module tb_ebpc_stream_mux;

    localparam int DW  = ebpc_pkg::DATA_W;
    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } word_t;

    typedef struct packed {
        logic          last;
        logic          src;
        logic [DW-1:0] data;
    } out_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CW-1:0] znzCnt, bpcCnt;
    logic          idle;

    ebpc_stream_mux_if #(.DATA_W(DW)) bus();

    ebpc_stream_mux #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .bus       (bus),
        .znz_cnt_o (znzCnt),
        .bpc_cnt_o (bpcCnt),
        .idle_o    (idle)
    );

    always #5 clk = ~clk;

    int nVec = 0;
    int nErr = 0;

    word_t znzQ[$];
    word_t bpcQ[$];
    int    vldPct = 100;
    int    rdyPct = 100;
    int    rdyHold = 0;
    bit    takeZ = 0, takeB = 0;
    bit    checkEn = 0;

    logic [DW-1:0] outLog[$];
    bit            srcLog[$];
    bit            lastLog[$];

    out_t held[$];
    bit   mZDone = 0, mBDone = 0, mActive = 0, mPrefB = 0;
    bit   mLock = 0, mLockB = 0;
    int   mCntZ = 0, mCntB = 0;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int satInc(input int v);
        return (v >= SAT) ? SAT : v + 1;
    endfunction

    // Per-cycle model and comparison, evaluated at the falling edge.
    task automatic checkOutput();
        bit   zReq, bReq, gZ, gB, inRdy, expVld, expIdle;
        out_t w, front;
        if (rst) begin
            cmp("rst_znz_rdy", bus.znz_rdy, 0);
            cmp("rst_bpc_rdy", bus.bpc_rdy, 0);
            mZDone = 0; mBDone = 0; mActive = 0; mPrefB = 0;
            mLock = 0; mLockB = 0; mCntZ = 0; mCntB = 0;
            held.delete();
            takeZ = 0; takeB = 0;
            return;
        end
        zReq = bus.znz_vld && !mZDone;
        bReq = bus.bpc_vld && !mBDone;
`ifdef EBPC_MUX_OUT_REG_EN
        gZ = zReq && (!bReq || !mPrefB);
        gB = bReq && !gZ;
        inRdy = (held.size() < 2);
`else
        if (mLock) begin
            gZ = zReq && !mLockB;
            gB = bReq && mLockB;
        end else begin
            gZ = zReq && (!bReq || !mPrefB);
            gB = bReq && !gZ;
        end
        inRdy = bus.rdy;
`endif
        cmp("znz_rdy", bus.znz_rdy, gZ && inRdy);
        cmp("bpc_rdy", bus.bpc_rdy, gB && inRdy);
        w.data = gB ? bus.bpc_data : bus.znz_data;
        w.src  = gB;
        w.last = gB ? (bus.bpc_last && mZDone) : (bus.znz_last && mBDone);
`ifdef EBPC_MUX_OUT_REG_EN
        expVld  = (held.size() > 0);
        front   = expVld ? held[0] : '0;
        expIdle = !mActive && (held.size() == 0);
`else
        expVld  = gZ || gB;
        front   = w;
        expIdle = !mActive;
`endif
        cmp("vld_o", bus.vld, expVld);
        if (expVld) begin
            cmp("data_o", bus.data, front.data);
            cmp("src_o", bus.src, front.src);
            cmp("last_o", bus.last, front.last);
        end
        cmp("idle_o", idle, expIdle);
        cmp("znz_cnt_o", znzCnt, mCntZ);
        cmp("bpc_cnt_o", bpcCnt, mCntB);

        if (bus.vld && bus.rdy) begin
            outLog.push_back(bus.data);
            srcLog.push_back(bus.src);
            lastLog.push_back(bus.last);
        end

`ifdef EBPC_MUX_OUT_REG_EN
        if (held.size() > 0 && bus.rdy) void'(held.pop_front());
`else
        mLock  = expVld && !bus.rdy;
        mLockB = gB;
`endif
        if ((gZ || gB) && inRdy) begin
            if (!mActive) begin
                mCntZ = 0; mCntB = 0; mActive = 1;
            end
            if (gZ) mCntZ = satInc(mCntZ);
            else    mCntB = satInc(mCntB);
`ifdef EBPC_MUX_OUT_REG_EN
            held.push_back(w);
`endif
            if (gZ && bus.znz_last) mZDone = 1;
            if (gB && bus.bpc_last) mBDone = 1;
            if (mZDone && mBDone) begin
                mZDone = 0; mBDone = 0; mActive = 0; mPrefB = 0;
            end else begin
                mPrefB = gZ;
            end
        end
        takeZ = bus.znz_vld && bus.znz_rdy;
        takeB = bus.bpc_vld && bus.bpc_rdy;
    endtask

    always @(negedge clk) if (checkEn) checkOutput();

    // Source behaviour: a presented word stays valid until it is taken.
    task automatic applyStimulus();
        if (takeZ) void'(znzQ.pop_front());
        if (znzQ.size() == 0) bus.znz_vld = 1'b0;
        else begin
            if (!bus.znz_vld || takeZ) bus.znz_vld = ($urandom_range(99) < vldPct);
            bus.znz_data = znzQ[0].data;
            bus.znz_last = znzQ[0].last;
        end
        if (takeB) void'(bpcQ.pop_front());
        if (bpcQ.size() == 0) bus.bpc_vld = 1'b0;
        else begin
            if (!bus.bpc_vld || takeB) bus.bpc_vld = ($urandom_range(99) < vldPct);
            bus.bpc_data = bpcQ[0].data;
            bus.bpc_last = bpcQ[0].last;
        end
        takeZ = 0; takeB = 0;
        if (rdyHold > 0) begin
            bus.rdy = 1'b0;
            rdyHold--;
        end else begin
            bus.rdy = ($urandom_range(99) < rdyPct);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1 applyStimulus();
    endtask

    function automatic logic [DW-1:0] zWord(input int tag, input int i);
        return {8'hA0, 8'(tag), 16'(i)};
    endfunction

    function automatic logic [DW-1:0] bWord(input int tag, input int i);
        return {8'hB0, 8'(tag), 16'(i)};
    endfunction

    task automatic loadFrame(input int tag, input int nz, input int nb);
        word_t w;
        for (int i = 1; i <= nz; i++) begin
            w.data = zWord(tag, i); w.last = (i == nz); znzQ.push_back(w);
        end
        for (int i = 1; i <= nb; i++) begin
            w.data = bWord(tag, i); w.last = (i == nb); bpcQ.push_back(w);
        end
    endtask

    task automatic clearLog();
        outLog.delete(); srcLog.delete(); lastLog.delete();
    endtask

    task automatic runUntilIdle();
        int n = 0;
        do begin
            cycle();
            n++;
        end while (!(znzQ.size() == 0 && bpcQ.size() == 0 && held.size() == 0 && !mActive) && n < 3000);
        if (n >= 3000) cmp("frame_done", 0, 1);
        cycle();
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [DW-1:0] expSeq[$];
        int lastCount;
        bus.znz_data = '0; bus.znz_last = 0; bus.znz_vld = 0;
        bus.bpc_data = '0; bus.bpc_last = 0; bus.bpc_vld = 0;
        bus.rdy = 0;
        checkEn = 1;
        $display("[TB] reset");
        repeat (2) @(posedge clk);
        #1 rst = 0;
        cmp("reset_idle", idle, 1);
        cmp("reset_vld", bus.vld, 0);
        cmp("reset_znz_cnt", znzCnt, 0);
        cmp("reset_bpc_cnt", bpcCnt, 0);

        $display("[TB] interleaved 3/2 frame");
        clearLog();
        loadFrame(0, 3, 2);
        runUntilIdle();
        expSeq = '{zWord(0,1), bWord(0,1), zWord(0,2), bWord(0,2), zWord(0,3)};
        cmp("ilv_count", outLog.size(), 5);
        for (int i = 0; i < 5 && i < outLog.size(); i++) begin
            cmp($sformatf("ilv_data%0d", i), outLog[i], expSeq[i]);
            cmp($sformatf("ilv_src%0d", i), srcLog[i], i % 2);
            cmp($sformatf("ilv_last%0d", i), lastLog[i], i == 4);
        end
        cmp("ilv_znz_cnt", znzCnt, 3);
        cmp("ilv_bpc_cnt", bpcCnt, 2);

        $display("[TB] early BPC last, next frame queued behind");
        clearLog();
        loadFrame(1, 5, 1);
        loadFrame(2, 1, 1);
        runUntilIdle();
        expSeq = '{zWord(1,1), bWord(1,1), zWord(1,2), zWord(1,3), zWord(1,4),
                   zWord(1,5), zWord(2,1), bWord(2,1)};
        cmp("early_count", outLog.size(), 8);
        for (int i = 0; i < 8 && i < outLog.size(); i++) begin
            cmp($sformatf("early_data%0d", i), outLog[i], expSeq[i]);
            cmp($sformatf("early_last%0d", i), lastLog[i], (i == 5) || (i == 7));
        end
        cmp("early_znz_cnt", znzCnt, 1);
        cmp("early_bpc_cnt", bpcCnt, 1);

        $display("[TB] output stall");
        clearLog();
        loadFrame(3, 4, 4);
        repeat (3) cycle();
        rdyHold = 5;
        runUntilIdle();
        expSeq.delete();
        for (int i = 1; i <= 4; i++) begin
            expSeq.push_back(zWord(3, i));
            expSeq.push_back(bWord(3, i));
        end
        cmp("stall_count", outLog.size(), 8);
        for (int i = 0; i < 8 && i < outLog.size(); i++)
            cmp($sformatf("stall_data%0d", i), outLog[i], expSeq[i]);

        $display("[TB] counter saturation");
        loadFrame(4, 20, 1);
        runUntilIdle();
        cmp("sat_znz_cnt", znzCnt, SAT);
        cmp("sat_bpc_cnt", bpcCnt, 1);
        loadFrame(5, 3, 1);
        runUntilIdle();
        cmp("after_sat_znz_cnt", znzCnt, 3);

        $display("[TB] reset mid-frame");
        loadFrame(6, 5, 5);
        repeat (3) cycle();
        rst = 1;
        znzQ.delete(); bpcQ.delete();
        bus.znz_vld = 0; bus.bpc_vld = 0;
        @(posedge clk);
        #1 rst = 0;
        cmp("rst_mid_vld", bus.vld, 0);
        cmp("rst_mid_last", bus.last, 0);
        cmp("rst_mid_src", bus.src, 0);
        cmp("rst_mid_data", bus.data, 0);
        cmp("rst_mid_idle", idle, 1);
        cmp("rst_mid_znz_cnt", znzCnt, 0);
        cmp("rst_mid_bpc_cnt", bpcCnt, 0);
        clearLog();
        loadFrame(7, 2, 2);
        runUntilIdle();
        lastCount = 0;
        foreach (lastLog[i]) lastCount += lastLog[i];
        cmp("post_rst_words", outLog.size(), 4);
        cmp("post_rst_lasts", lastCount, 1);
        cmp("post_rst_znz_cnt", znzCnt, 2);
        cmp("post_rst_bpc_cnt", bpcCnt, 2);

        $display("[TB] random frames");
        vldPct = 70;
        rdyPct = 70;
        for (int f = 0; f < 1000; f++) begin
            clearLog();
            loadFrame(f % 256, $urandom_range(1, 6), $urandom_range(1, 6));
            runUntilIdle();
        end
        cmp("final_idle", idle, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule

// File: doc/ebpc_stream_mux.md
EBPC_STREAM_MUX -- requirements
Module: ebpc_stream_mux

Interface
REQ-001 Parameter: DATA_W, from ebpc_pkg; width of all data words.
REQ-002 Parameter: CNT_W, default 16; width of per-stream word counters.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 znz_data_i / znz_last_i / znz_vld_i  input  DATA_W/1/1  ZNZ stream from EBPC encoder.
REQ-006 znz_rdy_o  output  1  ZNZ stream ready.
REQ-007 bpc_data_i / bpc_last_i / bpc_vld_i  input  DATA_W/1/1  BPC stream from EBPC encoder.
REQ-008 bpc_rdy_o  output  1  BPC stream ready.
REQ-009 data_o  output  DATA_W  merged output word.
REQ-010 src_o  output  1  source tag of data_o: 0 = ZNZ, 1 = BPC.
REQ-011 last_o  output  1  final word of the frame (both streams complete).
REQ-012 vld_o / rdy_i  output/input  1/1  merged output handshake.
REQ-013 znz_cnt_o / bpc_cnt_o  output  CNT_W  words forwarded per stream in current/last frame.
REQ-014 idle_o  output  1  no frame in progress and no word held.

Function
REQ-015 A transfer on any port SHALL occur only in a cycle where vld and rdy are both high.
REQ-016 FSM states SHALL be IDLE, RUN, ZNZ_DONE, BPC_DONE.
REQ-017 IDLE -> RUN on first accepted input word; counters SHALL clear to 0 in that cycle before counting it.
REQ-018 In RUN, both inputs valid: grant SHALL go to the stream not granted last (round-robin, ZNZ first after reset/IDLE).
REQ-019 In RUN, only one input valid: that stream SHALL be granted with no bubble.
REQ-020 A granted input SHALL see rdy = output-side ready; the non-granted input SHALL see rdy = 0.
REQ-021 Accepting znz_last_i in RUN -> ZNZ_DONE; accepting bpc_last_i in RUN -> BPC_DONE.
REQ-022 In ZNZ_DONE only BPC is accepted (znz_rdy_o = 0) and vice versa in BPC_DONE.
REQ-023 Accepting the remaining stream's last -> IDLE; that word SHALL carry last_o = 1; input lasts SHALL NOT otherwise propagate.
REQ-024 Both lasts available in the same cycle in RUN: round-robin grant applies; the second becomes last_o.
REQ-025 Counters SHALL increment per accepted word of their stream and saturate at 2^CNT_W-1; values held in IDLE.
REQ-026 data_o, src_o, last_o SHALL be stable while vld_o = 1 and rdy_i = 0.
REQ-027 idle_o = 1 iff state IDLE and no word held in output register (if present).

Reset
REQ-028 On rst_i = 1 at a clock edge: state IDLE, round-robin pointer ZNZ, counters 0, vld_o 0, last_o 0, src_o 0, data_o 0, any held word discarded.
REQ-029 Reset mid-frame SHALL abandon the frame; no last_o is emitted for it.
REQ-030 During reset cycle znz_rdy_o = bpc_rdy_o = 0.

Configuration
REQ-031 Macro EBPC_MUX_OUT_REG_EN defined: a 2-entry skid register SHALL sit on the output; latency input->data_o 1 cycle; input rdy independent of rdy_i combinationally; full throughput sustained.
REQ-032 Macro undefined: output SHALL be combinational from the granted input; latency 0; input rdy = rdy_i gated by grant.

Verification
REQ-033 ZNZ 3 words (A1,A2,A3 last), BPC 2 words (B1,B2 last), all valid, rdy_i = 1 -> out A1,B1,A2,B2,A3; src 0,1,0,1,0; last_o only on A3; cnt 3/2.
REQ-034 BPC last accepted first, ZNZ still sending 4 more words -> bpc_rdy_o = 0 until frame end; ZNZ words pass back-to-back; last_o on final ZNZ word.
REQ-035 rdy_i held 0 for 5 cycles mid-frame -> data_o/src_o stable, no input accepted, no word lost or duplicated.
REQ-036 CNT_W = 4, 20 ZNZ words -> znz_cnt_o saturates at 15; next frame starts at 1 after its first word.
REQ-037 rst_i pulsed after 2 of 5 words -> all outputs reset values next cycle, idle_o = 1, next frame counted from 0, no stale last_o.
REQ-038 Both builds (with/without EBPC_MUX_OUT_REG_EN), random vld/rdy, 1000 frames -> identical output word sequence vs reference model; latency 1 vs 0.
